mem_access_unit: RTL and testbench

- MEM-stage load/store unit; consumes the memory-control encoding produced by the main decoder (LS_bit, MemWrite, MemtoReg, Ext_op) plus the ALU effective address and the rt store data.
- Drives a request/ready data-memory port with byte enables, stalls the pipeline until the access completes, and returns width-extracted, sign/zero-extended load data to the writeback path.

---
 rtl/mem_pkg.sv | 65 ++++++
 rtl/load_formatter.sv | 68 ++++++
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage load/store path.
//   - LS_bit width encodings (word/half/byte)
//   - load extension encodings (sign/zero)
//   - access state encoding (IDLE/BUSY/DONE)
//   - helpers for address legality, byte enables and store-lane replication
// ---------------------------------------------------------------------------
package mem_pkg;

   localparam logic [1:0] LS_WORD  = 2'b00;
   localparam logic [1:0] LS_HALF  = 2'b01;
   localparam logic [1:0] LS_BYTE  = 2'b10;

   localparam logic       EXT_SIGN = 1'b0;
   localparam logic       EXT_ZERO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Width code is legal and the address is naturally aligned for it.
   function automatic logic is_legal(input logic [1:0] width, input logic [1:0] off);
      logic ok;
      case (width)
         LS_WORD: ok = (off == 2'b00);
         LS_HALF: ok = (off[0] == 1'b0);
         LS_BYTE: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte-enable pattern; big-endian mirrors lane L to lane 3-L.
   function automatic logic [3:0] calc_be(input logic [1:0] width, input logic [1:0] off,
                                          input logic big_endian);
      logic [1:0] lane;
      logic       hsel;
      logic [3:0] be;
      lane = big_endian ? (2'd3 - off) : off;
      hsel = big_endian ? ~off[1] : off[1];
      case (width)
         LS_BYTE: be = 4'b0001 << lane;
         LS_HALF: be = hsel ? 4'b1100 : 4'b0011;
         LS_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data replicated across all lanes so the enables alone pick the target.
   function automatic logic [31:0] calc_wdata(input logic [1:0] width, input logic [31:0] data);
      logic [31:0] res;
      case (width)
         LS_BYTE: res = {4{data[7:0]}};
         LS_HALF: res = {2{data[15:0]}};
         LS_WORD: res = data;
         default: res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// ---------------------------------------------------------------------------
// load_formatter
// Combinational: picks the addressed byte/half out of a read word and
// sign- or zero-extends it to 32 bits. Shared with a future cache path.
// Ports:
//   i_rdata  [31:0]  raw read word
//   i_offset [1:0]   byte offset addr[1:0]
//   i_width  [1:0]   LS_WORD / LS_HALF / LS_BYTE
//   i_ext            EXT_SIGN / EXT_ZERO
//   o_data   [31:0]  formatted load result
// ---------------------------------------------------------------------------
module load_formatter
   import mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
)(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_width,
   input  logic        i_ext,
   output logic [31:0] o_data
);

   logic [1:0]  w_lane;
   logic        w_hsel;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_lane = BIG_ENDIAN ? (2'd3 - i_offset) : i_offset;
   assign w_hsel = BIG_ENDIAN ? ~i_offset[1] : i_offset[1];
   assign w_half = w_hsel ? i_rdata[31:16] : i_rdata[15:0];

   // Byte lane select
   always_comb begin
      w_byte = 8'h00;
      case (w_lane)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = 8'h00;
      endcase
   end

   // Width extraction and extension
   always_comb begin
      o_data = 32'h0000_0000;
      case (i_width)
         LS_WORD: o_data = i_rdata;
         LS_HALF: begin
            case (i_ext)
               EXT_SIGN: o_data = {{16{w_half[15]}}, w_half};
               EXT_ZERO: o_data = {16'h0000, w_half};
               default:  o_data = 32'h0000_0000;
            endcase
         end
         LS_BYTE: begin
            case (i_ext)
               EXT_SIGN: o_data = {{24{w_byte[7]}}, w_byte};
               EXT_ZERO: o_data = {24'h00_0000, w_byte};
               default:  o_data = 32'h0000_0000;
            endcase
         end
         default: o_data = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store unit. Accepts a legal access in IDLE, issues a
// registered request on the data-memory port, waits for dmem_ready (or a
// MAX_WAIT-cycle timeout) in BUSY, and reports the result in DONE.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid, LS_bit, MemWrite,   decoded memory control from EX/MEM
//   MemtoReg, Ext_op, addr, wdata
//   stall                          hold the pipeline during the access
//   load_data, load_valid          formatted load result + strobe (DONE)
//   misalign                       illegal width/alignment, combinational
//   bus_err                        timeout strobe (DONE)
//   dmem_req/we/be/addr/wdata      data-memory request (registered)
//   dmem_ready, dmem_rdata         data-memory response
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int MAX_WAIT   = 16,
   parameter bit BIG_ENDIAN = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  LS_bit,
   input  logic        MemWrite,
   input  logic        MemtoReg,
   input  logic        Ext_op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign,
   output logic        bus_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata
);

   // Counter value seen in the last BUSY cycle before timing out.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_e      r_state;
   state_e      w_next;

   logic        r_dmem_req;
   logic        r_dmem_we;
   logic [3:0]  r_dmem_be;
   logic [31:0] r_dmem_addr;
   logic [31:0] r_dmem_wdata;
   logic [31:0] r_load_data;
   logic        r_load_valid;
   logic        r_bus_err;
   logic [7:0]  r_wait_cnt;
   logic        r_is_load;
   logic [1:0]  r_width;
   logic        r_ext;
   logic [1:0]  r_off;

   logic        w_op;
   logic        w_legal;
   logic        w_idle;
   logic        w_busy;
   logic        w_accept;
   logic        w_timeout;
   logic [31:0] w_fmt_data;

   assign w_op      = req_valid & (MemWrite | MemtoReg);
   assign w_legal   = is_legal(LS_bit, addr[1:0]);
   assign w_idle    = (r_state == ST_IDLE);
   assign w_busy    = (r_state == ST_BUSY);
   assign w_accept  = w_idle & w_op & w_legal;
   // Ready has priority: timeout only counts when ready is absent.
   assign w_timeout = w_busy & ~dmem_ready & (r_wait_cnt == WAIT_LAST);

   assign misalign  = w_idle & w_op & ~w_legal;
   assign stall     = w_accept | w_busy;

   load_formatter #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_fmt (
      .i_rdata  (dmem_rdata),
      .i_offset (r_off),
      .i_width  (r_width),
      .i_ext    (r_ext),
      .o_data   (w_fmt_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = ST_BUSY;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (dmem_ready | w_timeout) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_BUSY;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Request, wait counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_be    <= 4'b0000;
         r_dmem_addr  <= 32'h0000_0000;
         r_dmem_wdata <= 32'h0000_0000;
         r_load_data  <= 32'h0000_0000;
         r_load_valid <= 1'b0;
         r_bus_err    <= 1'b0;
         r_wait_cnt   <= 8'd0;
         r_is_load    <= 1'b0;
         r_width      <= LS_WORD;
         r_ext        <= EXT_SIGN;
         r_off        <= 2'b00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_load_valid <= 1'b0;
               r_bus_err    <= 1'b0;
               if (w_accept) begin
                  r_dmem_req   <= 1'b1;
                  r_dmem_we    <= MemWrite;
                  r_dmem_be    <= calc_be(LS_bit, addr[1:0], BIG_ENDIAN);
                  r_dmem_addr  <= {addr[31:2], 2'b00};
                  r_dmem_wdata <= calc_wdata(LS_bit, wdata);
                  // Store wins when both MemWrite and MemtoReg are set.
                  r_is_load    <= MemtoReg & ~MemWrite;
                  r_width      <= LS_bit;
                  r_ext        <= Ext_op;
                  r_off        <= addr[1:0];
                  r_wait_cnt   <= 8'd0;
               end
            end
            ST_BUSY: begin
               r_wait_cnt <= r_wait_cnt + 8'd1;
               if (dmem_ready) begin
                  r_dmem_req   <= 1'b0;
                  r_dmem_we    <= 1'b0;
                  r_load_valid <= r_is_load;
                  if (r_is_load) begin
                     r_load_data <= w_fmt_data;
                  end
               end else if (w_timeout) begin
                  r_dmem_req  <= 1'b0;
                  r_dmem_we   <= 1'b0;
                  r_load_data <= 32'h0000_0000;
                  r_bus_err   <= 1'b1;
               end
            end
            ST_DONE: begin
               r_load_valid <= 1'b0;
               r_bus_err    <= 1'b0;
            end
            default: begin
               r_dmem_req   <= 1'b0;
               r_dmem_we    <= 1'b0;
               r_load_valid <= 1'b0;
               r_bus_err    <= 1'b0;
            end
         endcase
      end
   end

   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_be    = r_dmem_be;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_wdata = r_dmem_wdata;
   assign load_data  = r_load_data;
   assign load_valid = r_load_valid;
   assign bus_err    = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed and randomised accesses against mem_access_unit, with expected
// enables, store lanes and load results computed arithmetically.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int MAX_WAIT = 4;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic [1:0]  LS_bit;
   logic        MemWrite;
   logic        MemtoReg;
   logic        Ext_op;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] load_data;
   logic        load_valid;
   logic        misalign;
   logic        bus_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   mem_access_unit #(
      .MAX_WAIT   (MAX_WAIT),
      .BIG_ENDIAN (1'b0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .LS_bit     (LS_bit),
      .MemWrite   (MemWrite),
      .MemtoReg   (MemtoReg),
      .Ext_op     (Ext_op),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .misalign   (misalign),
      .bus_err    (bus_err),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_be    (dmem_be),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata)
   );

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---- reference model -------------------------------------------------
   function automatic logic m_legal(input logic [1:0] ls, input logic [31:0] a);
      if (ls == 2'b11)      return 1'b0;
      else if (ls == 2'b01) return (a % 32'd2) == 32'd0;
      else if (ls == 2'b00) return (a % 32'd4) == 32'd0;
      else                  return 1'b1;
   endfunction

   function automatic logic [31:0] m_be(input logic [1:0] ls, input logic [31:0] a);
      logic [31:0] off;
      off = a % 32'd4;
      if (ls == 2'b10)      return 32'd1 << off;
      else if (ls == 2'b01) return 32'd3 << off;
      else                  return 32'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] ls, input logic [31:0] d);
      if (ls == 2'b10)      return (d % 32'd256) * 32'h0101_0101;
      else if (ls == 2'b01) return (d % 32'd65536) * 32'h0001_0001;
      else                  return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] ls, input logic [31:0] a,
                                          input logic ext, input logic [31:0] rd);
      logic [31:0] v;
      v = rd >> (32'd8 * (a % 32'd4));
      if (ls == 2'b10) begin
         v = v % 32'd256;
         if (!ext && v >= 32'd128) v = v - 32'd256;
      end else if (ls == 2'b01) begin
         v = v % 32'd65536;
         if (!ext && v >= 32'd32768) v = v - 32'd65536;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // ---- comparison ------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         req_valid  = 1'b0;
         dmem_ready = 1'b0;
      end
   endtask

   // One instruction from presentation to completion. ready_at = BUSY cycle
   // in which dmem_ready is raised; outside 1..MAX_WAIT means never.
   task automatic run_access(input logic we, input logic ld, input logic [1:0] ls,
                             input logic ext, input logic [31:0] a, input logic [31:0] wd,
                             input int ready_at, input logic [31:0] rd, input string tag);
      logic is_load;
      logic tmo;
      int   n_busy;
      is_load = ld & ~we;
      @(posedge clk); #1;
      req_valid  = 1'b1;
      MemWrite   = we;
      MemtoReg   = ld;
      LS_bit     = ls;
      Ext_op     = ext;
      addr       = a;
      wdata      = wd;
      dmem_ready = 1'b0;
      dmem_rdata = rd;
      @(negedge clk);
      if (!m_legal(ls, a)) begin
         check({tag, "_misalign"}, misalign, 32'd1);
         check({tag, "_stall"}, stall, 32'd0);
         check({tag, "_req"}, dmem_req, 32'd0);
         @(posedge clk); #1;
         req_valid = 1'b0;
         @(negedge clk);
         check({tag, "_req_after"}, dmem_req, 32'd0);
         check({tag, "_stall_after"}, stall, 32'd0);
      end else begin
         check({tag, "_misalign"}, misalign, 32'd0);
         check({tag, "_stall_acc"}, stall, 32'd1);
         check({tag, "_req_acc"}, dmem_req, 32'd0);
         tmo    = (ready_at < 1) || (ready_at > MAX_WAIT);
         n_busy = tmo ? MAX_WAIT : ready_at;
         for (int k = 1; k <= n_busy; k++) begin
            @(posedge clk); #1;
            dmem_ready = (k == ready_at);
            @(negedge clk);
            check({tag, "_stall_busy"}, stall, 32'd1);
            check({tag, "_req"}, dmem_req, 32'd1);
            check({tag, "_we"}, dmem_we, {31'd0, we});
            check({tag, "_be"}, dmem_be, m_be(ls, a));
            check({tag, "_addr"}, dmem_addr, a - (a % 32'd4));
            check({tag, "_wdata"}, dmem_wdata, m_wdata(ls, wd));
            check({tag, "_lv_busy"}, load_valid, 32'd0);
            check({tag, "_be_busy"}, bus_err, 32'd0);
         end
         @(posedge clk); #1;
         dmem_ready = 1'b0;
         @(negedge clk);
         check({tag, "_stall_done"}, stall, 32'd0);
         check({tag, "_req_done"}, dmem_req, 32'd0);
         check({tag, "_load_valid"}, load_valid, {31'd0, is_load & ~tmo});
         check({tag, "_bus_err"}, bus_err, {31'd0, tmo});
         if (tmo) begin
            check({tag, "_ldata_tmo"}, load_data, 32'd0);
         end else if (is_load) begin
            check({tag, "_ldata"}, load_data, m_load(ls, a, ext, rd));
         end
      end
   endtask

   // ---- stimulus --------------------------------------------------------
   initial begin
      logic        r_we;
      logic        r_ld;
      logic [1:0]  r_ls;
      logic [31:0] r_a;
      logic [31:0] r_rnd;

      rst        = 1'b1;
      req_valid  = 1'b0;
      LS_bit     = 2'b00;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      Ext_op     = 1'b0;
      addr       = 32'd0;
      wdata      = 32'd0;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", dmem_req, 32'd0);
      check("rst_we", dmem_we, 32'd0);
      check("rst_be", dmem_be, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_ldata", load_data, 32'd0);
      check("rst_lv", load_valid, 32'd0);
      check("rst_berr", bus_err, 32'd0);
      check("rst_stall", stall, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // SB at 0x1003, ready on first BUSY cycle
      run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0000_00A5, 1, 32'd0, "sb");
      idle(1);
      // LH / LHU at 0x2002
      run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'd0, 2, 32'h8001_1234, "lh");
      run_access(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'd0, 3, 32'h8001_1234, "lhu");
      idle(1);
      // misaligned LW and illegal width
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_3001, 32'd0, 1, 32'd0, "lw_mis");
      run_access(1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'd0, 1, 32'd0, "ls11");
      // timeout
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0040, 32'd0, 0, 32'hDEAD_BEEF, "lw_tmo");
      // ready in the same cycle the counter expires
      run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0044, 32'd0, MAX_WAIT, 32'h1357_9BDF, "lw_edge");
      idle(1);

      // reset while BUSY with an LB pending
      @(posedge clk); #1;
      req_valid = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; LS_bit = 2'b10;
      Ext_op = 1'b0; addr = 32'h0000_0051; dmem_ready = 1'b0;
      @(negedge clk);
      check("rstb_stall", stall, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rstb_req_busy", dmem_req, 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      check("rstb_req", dmem_req, 32'd0);
      check("rstb_stall_after", stall, 32'd0);
      check("rstb_lv", load_valid, 32'd0);
      check("rstb_berr", bus_err, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstb_lv2", load_valid, 32'd0);
      check("rstb_berr2", bus_err, 32'd0);
      run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0051, 32'd0, 2, 32'h0000_9A00, "lb_after_rst");
      idle(1);

      // back-to-back SW then LBU
      run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_5678, 1, 32'd0, "sw_b2b");
      run_access(1'b0, 1'b1, 2'b10, 1'b1, 32'h0000_0010, 32'd0, 1, 32'h0000_00F0, "lbu_b2b");

      // randomised accesses
      for (int n = 0; n < 60; n++) begin
         r_we = 1'($urandom_range(0, 1));
         r_ld = r_we ? 1'($urandom_range(0, 1)) : 1'b1;
         r_ls = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_rnd = $urandom();
         r_a = r_rnd - (r_rnd % 32'd4);
         if (r_ls == 2'b10 || $urandom_range(0, 4) == 0) begin
            r_a = r_a + 32'($urandom_range(0, 3));
         end else if (r_ls == 2'b01) begin
            r_a = r_a + 32'd2 * 32'($urandom_range(0, 1));
         end
         run_access(r_we, r_ld, r_ls, 1'($urandom_range(0, 1)), r_a, $urandom(),
                    $urandom_range(0, MAX_WAIT + 1), $urandom(), "rnd");
         if ($urandom_range(0, 2) == 0) idle(1);
      end

      idle(2);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
